// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving an SRAM-like bus; define MEM_ADDR_EXC_EN for alignment exceptions
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [2:0]    mem_op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          adel,
    output logic          ades,
    output logic [AW-1:0] badvaddr,
    output logic          d_req,
    output logic          d_wr,
    output logic [1:0]    d_size,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_wdata,
    output logic [3:0]    d_wstrb,
    input  logic          d_addr_ok,
    input  logic          d_data_ok,
    input  logic [DW-1:0] d_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0]    state_q, state_d;
    logic          req_q, req_d, wr_q, wr_d, sx_q, sx_d;
    logic [1:0]    size_q, size_d, size_in;
    logic [AW-1:0] addr_q, addr_d, eff_addr;
    logic [DW-1:0] wdata_q, wdata_d, wdata_in, rdata_q, rdata_d, ld_fmt, ld_sh;
    logic [3:0]    wstrb_q, wstrb_d, wstrb_in;
    logic [15:0]   ld_half;
    logic          go, exc, load;
    assign go = state_q == IDLE & (memread | memwrite);
    assign size_in = memwrite ? (mem_op == 3'b010 ? 2'd0 : mem_op == 3'b001 ? 2'd1 : 2'd2)
                              : (mem_op[2] ? {1'b0, ~mem_op[1]} : 2'd2);
`ifdef MEM_ADDR_EXC_EN
    logic          adel_q, ades_q;
    logic [AW-1:0] badv_q;
    assign exc = (size_in == 2'd1 & addr[0]) | (size_in == 2'd2 & |addr[1:0]);
    assign eff_addr = addr;
    // Raise the alignment fault for the single DONE cycle and remember the faulting address
    always_ff @(posedge clk) begin
        if (!rst) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
            badv_q <= '0;
        end else begin
            adel_q <= go & exc & ~memwrite;
            ades_q <= go & exc & memwrite;
            badv_q <= go & exc ? addr : badv_q;
        end
    end
    assign adel = adel_q;
    assign ades = ades_q;
    assign badvaddr = badv_q;
`else
    assign exc = 1'b0;
    assign eff_addr = {addr[AW-1:2], size_in == 2'd2 ? 2'b00 : {addr[1], size_in == 2'd1 ? 1'b0 : addr[0]}};
    assign adel = 1'b0;
    assign ades = 1'b0;
    assign badvaddr = '0;
`endif
    assign load = go & ~exc;
    assign wstrb_in = size_in == 2'd0 ? 4'b0001 << eff_addr[1:0] : size_in == 2'd1 ? (eff_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_in = size_in == 2'd0 ? {4{wdata[7:0]}} : size_in == 2'd1 ? {2{wdata[15:0]}} : wdata;
    assign ld_sh = d_rdata >> {addr_q[1:0], 3'b000};
    assign ld_half = addr_q[1] ? d_rdata[31:16] : d_rdata[15:0];
    assign ld_fmt = size_q == 2'd0 ? {{24{sx_q & ld_sh[7]}}, ld_sh[7:0]}
                  : size_q == 2'd1 ? {{16{sx_q & ld_half[15]}}, ld_half} : d_rdata;
    // Next-state: sequence IDLE -> REQ -> WAIT -> DONE, registering bus fields when a request is launched
    always_comb begin
        state_d = go ? (exc ? DONE : REQ)
                : state_q == REQ ? (d_addr_ok ? WAIT : REQ)
                : state_q == WAIT ? (d_data_ok ? DONE : WAIT)
                : IDLE;
        req_d = load | (state_q == REQ & ~d_addr_ok);
        wr_d = load ? memwrite : wr_q;
        sx_d = load ? ~mem_op[0] : sx_q;
        size_d = load ? size_in : size_q;
        addr_d = load ? eff_addr : addr_q;
        wdata_d = load ? (memwrite ? wdata_in : '0) : wdata_q;
        wstrb_d = load ? (memwrite ? wstrb_in : 4'b0000) : wstrb_q;
        rdata_d = state_q == WAIT & d_data_ok & ~wr_q ? ld_fmt : rdata_q;
    end
    // State and bus registers with synchronous active-low reset that abandons any access
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q <= 1'b0;
            wr_q <= 1'b0;
            sx_q <= 1'b0;
            size_q <= 2'd0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            wr_q <= wr_d;
            sx_q <= sx_d;
            size_q <= size_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end
    assign stall = go | state_q == REQ | state_q == WAIT;
    assign done = state_q == DONE;
    assign rdata = rdata_q;
    assign d_req = req_q;
    assign d_wr = wr_q;
    assign d_size = size_q;
    assign d_addr = addr_q;
    assign d_wdata = wdata_q;
    assign d_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, adel, ades, d_req, d_wr;
    logic [31:0] rdata, badvaddr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok = 1'b0, d_data_ok = 1'b0;
    logic [31:0] d_rdata = '0;
    int          n_chk = 0, n_fail = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .adel(adel), .ades(ades), .badvaddr(badvaddr), .d_req(d_req), .d_wr(d_wr),
        .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_chk(input string tag, input logic w, input logic [31:0] ea, input logic [1:0] es,
                           input logic [3:0] est, input logic [31:0] ewd);
        check({tag, " d_req"}, d_req, 1);
        check({tag, " stall"}, stall, 1);
        check({tag, " d_wr"}, d_wr, w);
        check({tag, " d_addr"}, d_addr, ea);
        check({tag, " d_size"}, d_size, es);
        check({tag, " d_wstrb"}, d_wstrb, est);
        if (w) check({tag, " d_wdata"}, d_wdata, ewd);
    endtask

    task automatic run(input string tag, input logic w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input int aok_wait, input logic [31:0] rd,
                       input logic [31:0] ea, input logic [1:0] es, input logic [3:0] est,
                       input logic [31:0] ewd, input logic [31:0] erd);
        memread = ~w;
        memwrite = w;
        mem_op = op;
        addr = a;
        wdata = wd;
        #1;
        check({tag, " c0 stall"}, stall, 1);
        check({tag, " c0 d_req"}, d_req, 0);
        tick();
        bus_chk({tag, " c1"}, w, ea, es, est, ewd);
        for (int i = 0; i < aok_wait; i++) begin
            tick();
            bus_chk($sformatf("%s hold%0d", tag, i), w, ea, es, est, ewd);
        end
        d_addr_ok = 1'b1;
        tick();
        d_addr_ok = 1'b0;
        check({tag, " wait d_req"}, d_req, 0);
        check({tag, " wait stall"}, stall, 1);
        check({tag, " wait done"}, done, 0);
        d_data_ok = 1'b1;
        d_rdata = rd;
        tick();
        d_data_ok = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " done stall"}, stall, 0);
        check({tag, " done adel"}, adel, 0);
        check({tag, " done ades"}, ades, 0);
        if (!w) check({tag, " rdata"}, rdata, erd);
        tick();
        check({tag, " done clr"}, done, 0);
    endtask

`ifdef MEM_ADDR_EXC_EN
    task automatic run_exc(input string tag, input logic w, input logic [2:0] op, input logic [31:0] a);
        memread = ~w;
        memwrite = w;
        mem_op = op;
        addr = a;
        #1;
        check({tag, " c0 stall"}, stall, 1);
        tick();
        memread = 1'b0;
        memwrite = 1'b0;
        check({tag, " d_req"}, d_req, 0);
        check({tag, " done"}, done, 1);
        check({tag, " stall"}, stall, 0);
        check({tag, " adel"}, adel, ~w);
        check({tag, " ades"}, ades, w);
        check({tag, " badvaddr"}, badvaddr, a);
        tick();
        check({tag, " done clr"}, done, 0);
        check({tag, " adel clr"}, adel, 0);
        check({tag, " ades clr"}, ades, 0);
    endtask
`endif

    initial begin
        tick();
        tick();
        check("rst done", done, 0);
        check("rst d_req", d_req, 0);
        check("rst d_addr", d_addr, 0);
        check("rst rdata", rdata, 0);
        check("rst stall", stall, 0);
        rst = 1'b1;
        tick();
        run("SW", 1, 3'b000, 32'h100, 32'hDEADBEEF, 0, 0, 32'h100, 2, 4'b1111, 32'hDEADBEEF, 0);
        run("SB", 1, 3'b010, 32'h103, 32'h000000A5, 0, 0, 32'h103, 0, 4'b1000, 32'hA5A5A5A5, 0);
        run("SH", 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0, 32'h102, 1, 4'b1100, 32'hBEEFBEEF, 0);
        run("LB", 0, 3'b110, 32'h201, 0, 0, 32'h12348056, 32'h201, 0, 4'b0000, 0, 32'hFFFFFF80);
        run("LBU", 0, 3'b111, 32'h201, 0, 0, 32'h12348056, 32'h201, 0, 4'b0000, 0, 32'h00000080);
        run("LH", 0, 3'b100, 32'h202, 0, 0, 32'h12348056, 32'h202, 1, 4'b0000, 0, 32'h00001234);
        run("LHU", 0, 3'b101, 32'h200, 0, 0, 32'h12348056, 32'h200, 1, 4'b0000, 0, 32'h00008056);
        run("LHs", 0, 3'b100, 32'h200, 0, 0, 32'h12348056, 32'h200, 1, 4'b0000, 0, 32'hFFFF8056);
        run("LW", 0, 3'b000, 32'h300, 0, 0, 32'hCAFEF00D, 32'h300, 2, 4'b0000, 0, 32'hCAFEF00D);
        run("Lund", 0, 3'b011, 32'h304, 0, 0, 32'h87654321, 32'h304, 2, 4'b0000, 0, 32'h87654321);
        run("SWslow", 1, 3'b000, 32'h104, 32'h01020304, 5, 0, 32'h104, 2, 4'b1111, 32'h01020304, 0);
`ifdef MEM_ADDR_EXC_EN
        run_exc("LWmis", 0, 3'b000, 32'h101);
        run_exc("SHmis", 1, 3'b001, 32'h3);
`else
        run("LWmask", 0, 3'b000, 32'h101, 0, 0, 32'h11223344, 32'h100, 2, 4'b0000, 0, 32'h11223344);
        run("LHUmask", 0, 3'b101, 32'h203, 0, 0, 32'hABCD1234, 32'h202, 1, 4'b0000, 0, 32'h0000ABCD);
        run("SWmask", 1, 3'b000, 32'h107, 32'h55667788, 0, 0, 32'h104, 2, 4'b1111, 32'h55667788, 0);
        run("SHmask", 1, 3'b001, 32'h103, 32'h00001357, 0, 0, 32'h102, 1, 4'b1100, 32'h13571357, 0);
`endif
        memread = 1'b1;
        mem_op = 3'b000;
        addr = 32'h400;
        tick();
        d_addr_ok = 1'b1;
        tick();
        d_addr_ok = 1'b0;
        check("rstw pre stall", stall, 1);
        rst = 1'b0;
        memread = 1'b0;
        tick();
        check("rstw d_req", d_req, 0);
        check("rstw d_addr", d_addr, 0);
        check("rstw d_wstrb", d_wstrb, 0);
        check("rstw d_wdata", d_wdata, 0);
        check("rstw rdata", rdata, 0);
        check("rstw done", done, 0);
        check("rstw stall", stall, 0);
        rst = 1'b1;
        d_data_ok = 1'b1;
        d_rdata = 32'h99999999;
        tick();
        d_data_ok = 1'b0;
        check("rstw late done", done, 0);
        tick();
        check("rstw late done2", done, 0);
        check("rstw late rdata", rdata, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine for the MIPS core; consumes the decoder's memtoreg, memwrite and mem_op controls.
- Turns each load/store into one transaction on the SRAM-like data bus (req/addr_ok/data_ok).
- Generates byte strobes and replicated store data; extracts and sign/zero-extends load data.
- Holds the pipeline with stall until the access completes.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; lane logic assumes 4 bytes)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- memread  in  1  load request (decoder memtoreg)
- memwrite  in  1  store request
- mem_op  in  3  000 word, 110 LB, 111 LBU, 100 LH, 101 LHU, 010 SB, 001 SH
- addr  in  AW  effective address
- wdata  in  DW  store source register value
- stall  out  1  pipeline hold (combinational)
- done  out  1  one-cycle completion pulse
- rdata  out  DW  formatted load result, valid with done
- adel  out  1  load address error, valid with done
- ades  out  1  store address error, valid with done
- badvaddr  out  AW  faulting address, valid with done when adel|ades
- d_req  out  1  bus request
- d_wr  out  1  1 = write
- d_size  out  2  0 byte, 1 half, 2 word
- d_addr  out  AW  bus address (full byte address)
- d_wdata  out  DW  replicated store data
- d_wstrb  out  4  byte enables (0000 on reads)
- d_addr_ok  in  1  request accepted
- d_data_ok  in  1  read data valid / write complete
- d_rdata  in  DW  read data

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; d_req, d_wr, d_size, d_addr, d_wdata, d_wstrb, done, rdata, adel, ades, badvaddr all 0. Reset mid-transaction abandons the access; a d_data_ok arriving in IDLE is ignored.
- States and transitions:
  - IDLE: if memread|memwrite, latch op/addr/wdata and kind. memwrite wins if both are set. Misaligned -> DONE with the exception flag. Otherwise -> REQ with d_req=1 and bus fields registered.
  - REQ: hold d_req and all bus fields stable until d_addr_ok. On d_addr_ok -> WAIT with d_req=0. d_data_ok is not sampled in REQ.
  - WAIT: on d_data_ok, capture formatted d_rdata (reads) -> DONE.
  - DONE: done=1 for exactly one cycle with rdata/adel/ades/badvaddr -> IDLE unconditionally. done, adel and ades clear on leaving DONE; rdata and badvaddr hold until the next DONE.
- stall = (IDLE & (memread|memwrite)) | REQ | WAIT. Low in DONE, so the pipeline advances on the DONE edge. Upstream holds its inputs stable while stall=1.
- Minimum latency: request seen in cycle 0, addr_ok in cycle 1, data_ok in cycle 2, done in cycle 3. Every access costs at least one IDLE cycle.
- Alignment: half needs addr[0]==0; word needs addr[1:0]==00. Misalignment sets adel (load) or ades (store) with badvaddr=addr, issues no bus request, and has a 1-cycle stall.
- Store formatting:
  - SB: d_wstrb = 0001<<addr[1:0]; d_wdata = {4{wdata[7:0]}}.
  - SH: d_wstrb = addr[1]?1100:0011; d_wdata = {2{wdata[15:0]}}.
  - SW: d_wstrb = 1111; d_wdata = wdata.
- Load formatting: select the lane by the latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits through.
- Undefined mem_op codes on a load are treated as word.

Optional Feature:
- Macro MEM_ADDR_EXC_EN.
- Defined: alignment checks and adel/ades/badvaddr behave as above.
- Undefined:
  - adel, ades and badvaddr are tied 0 and no exception path exists.
  - Address low bits are masked instead of checked: word uses addr[1:0]=00, half uses addr[0]=0, for both d_addr and lane selection.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, addr_ok cycle 1, data_ok cycle 2 -> d_wstrb=1111, d_size=2, done in cycle 3, stall high cycles 0-2.
- SB addr=0x103, wdata=0x000000A5 -> d_wstrb=1000, d_wdata=0xA5A5A5A5, d_size=0; SH addr=0x102 -> d_wstrb=1100.
- LB addr=0x201 with d_rdata=0x12348056 -> rdata=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x202 -> 0x00001234. LHU addr=0x200 -> 0x00008056.
- d_addr_ok held low 5 cycles -> d_req and bus fields stable for all 5 cycles, stall stays high, done exactly once after data_ok.
- With MEM_ADDR_EXC_EN: LW addr=0x101 -> no d_req, done+adel=1, badvaddr=0x101 one cycle after the request. SH addr=0x3 -> ades=1. Without the macro: LW 0x101 reads word 0x100.
- rst=0 while in WAIT -> next cycle IDLE with all outputs 0; a later d_data_ok is ignored and no done pulse occurs.
